// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - instruction sequencer driving an external registered ALU
module alu_sequencer #(
  parameter int DATA_W = 14,
  parameter int NREGS  = 16,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W+11:0]  instr_in,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              disp_hex,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_rst_flags,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [2:0]        alu_flags,
  output logic              running,
  output logic              halted,
  output logic              cond,
  output logic              parity,
  output logic [3:0]        err
);

  // Instruction-set opcodes; 30 and 31 are unassigned.
  localparam logic [OP_W-1:0] OP_ADD     = 'd0;
  localparam logic [OP_W-1:0] OP_SUB     = 'd1;
  localparam logic [OP_W-1:0] OP_MUL     = 'd2;
  localparam logic [OP_W-1:0] OP_DIV     = 'd3;
  localparam logic [OP_W-1:0] OP_MOD     = 'd4;
  localparam logic [OP_W-1:0] OP_ANDB    = 'd5;
  localparam logic [OP_W-1:0] OP_ORB     = 'd6;
  localparam logic [OP_W-1:0] OP_NOTB    = 'd7;
  localparam logic [OP_W-1:0] OP_XORB    = 'd8;
  localparam logic [OP_W-1:0] OP_TWOCOMP = 'd9;
  localparam logic [OP_W-1:0] OP_LSLN    = 'd10;
  localparam logic [OP_W-1:0] OP_LSRN    = 'd11;
  localparam logic [OP_W-1:0] OP_LSL     = 'd12;
  localparam logic [OP_W-1:0] OP_LSR     = 'd13;
  localparam logic [OP_W-1:0] OP_ASL     = 'd14;
  localparam logic [OP_W-1:0] OP_ASR     = 'd15;
  localparam logic [OP_W-1:0] OP_RSL     = 'd16;
  localparam logic [OP_W-1:0] OP_RSR     = 'd17;
  localparam logic [OP_W-1:0] OP_CPY     = 'd18;
  localparam logic [OP_W-1:0] OP_CMPLT   = 'd19;
  localparam logic [OP_W-1:0] OP_CMPGT   = 'd20;
  localparam logic [OP_W-1:0] OP_CMPEQ   = 'd21;
  localparam logic [OP_W-1:0] OP_CMPNE   = 'd22;
  localparam logic [OP_W-1:0] OP_START   = 'd23;
  localparam logic [OP_W-1:0] OP_END     = 'd24;
  localparam logic [OP_W-1:0] OP_WAIT    = 'd25;
  localparam logic [OP_W-1:0] OP_LDR     = 'd26;
  localparam logic [OP_W-1:0] OP_STR     = 'd27;
  localparam logic [OP_W-1:0] OP_DISPB   = 'd28;
  localparam logic [OP_W-1:0] OP_DISPH   = 'd29;

  localparam logic [2:0] FLAG_TRUE    = 3'd1;
  localparam logic [2:0] FLAG_OVF     = 3'd3;
  localparam logic [2:0] FLAG_NEG     = 3'd4;
  localparam logic [2:0] FLAG_INVALID = 3'd5;
  localparam logic [2:0] FLAG_ODD     = 3'd7;

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, EXEC, WB, WAITC, HALT} state_t;

  state_t            state;
  logic [DATA_W-1:0] regFile [NREGS];
  logic [OP_W-1:0]   curOp;
  logic [3:0]        curRd;
  logic [3:0]        curRa;
  logic [3:0]        curRb;
  logic [3:0]        waitCnt;

  logic [OP_W-1:0]   inOp;
  logic [3:0]        inRd;
  logic [3:0]        inRa;
  logic [3:0]        inRb;
  logic              xfer;

  assign inOp = instr_in[OP_W+11:12];
  assign inRd = instr_in[11:8];
  assign inRa = instr_in[7:4];
  assign inRb = instr_in[3:0];
  assign xfer = instr_valid & instr_ready;

  // Opcodes whose ALU result is written back to rd.
  function automatic logic isWriteOp(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_ANDB, OP_ORB, OP_NOTB, OP_XORB,
      OP_TWOCOMP, OP_LSLN, OP_LSRN, OP_LSL, OP_LSR, OP_ASL, OP_ASR,
      OP_RSL, OP_RSR, OP_CPY: isWriteOp = 1'b1;
      default:                isWriteOp = 1'b0;
    endcase
  endfunction

  // Opcodes that only update the compare outcome.
  function automatic logic isCmpOp(input logic [OP_W-1:0] op);
    case (op)
      OP_CMPLT, OP_CMPGT, OP_CMPEQ, OP_CMPNE: isCmpOp = 1'b1;
      default:                               isCmpOp = 1'b0;
    endcase
  endfunction

  // Sequencer FSM: fetch/dispatch, ALU issue pipeline, local ops and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      for (int i = 0; i < NREGS; i++) regFile[i] <= '0;
      curOp         <= '0;
      curRd         <= '0;
      curRa         <= '0;
      curRb         <= '0;
      waitCnt       <= '0;
      instr_ready   <= 1'b0;
      st_data       <= '0;
      st_valid      <= 1'b0;
      disp_data     <= '0;
      disp_valid    <= 1'b0;
      disp_hex      <= 1'b0;
      alu_op        <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_rst_flags <= 1'b1;
      running       <= 1'b0;
      halted        <= 1'b0;
      cond          <= 1'b0;
      parity        <= 1'b0;
      err           <= '0;
    end else begin
      st_valid   <= 1'b0;
      disp_valid <= 1'b0;
      case (state)
        IDLE: begin
          instr_ready   <= 1'b1;
          alu_rst_flags <= 1'b0;
          if (xfer && inOp == OP_START) begin
            state   <= FETCH;
            running <= 1'b1;
          end
        end
        FETCH: begin
          if (xfer) begin
            curOp <= inOp;
            curRd <= inRd;
            curRa <= inRa;
            curRb <= inRb;
            case (inOp)
              OP_START: ;
              OP_END: begin
                state       <= HALT;
                instr_ready <= 1'b0;
                running     <= 1'b0;
                halted      <= 1'b1;
              end
              OP_WAIT: begin
                state       <= WAITC;
                instr_ready <= 1'b0;
                waitCnt     <= inRb;
              end
              OP_LDR: regFile[inRd] <= ld_data;
              OP_STR: begin
                st_data  <= regFile[inRa];
                st_valid <= 1'b1;
              end
              OP_DISPB, OP_DISPH: begin
                disp_data  <= regFile[inRa];
                disp_hex   <= (inOp == OP_DISPH);
                disp_valid <= 1'b1;
              end
              default: begin
                // Flag clear is raised now so it covers exactly the ISSUE cycle.
                state         <= ISSUE;
                instr_ready   <= 1'b0;
                alu_rst_flags <= 1'b1;
              end
            endcase
          end
        end
        ISSUE: begin
          alu_op        <= curOp;
          alu_a         <= regFile[curRa];
          alu_b         <= regFile[curRb];
          alu_rst_flags <= 1'b0;
          state         <= EXEC;
        end
        EXEC: begin
          state <= WB;
        end
        WB: begin
          if (isWriteOp(curOp)) regFile[curRd] <= alu_result;
          else if (isCmpOp(curOp)) cond <= (alu_flags == FLAG_TRUE);
          else if (curOp == OP_MOD) parity <= (alu_flags == FLAG_ODD);
          else err[3] <= 1'b1;
          if (alu_flags == FLAG_OVF) err[0] <= 1'b1;
          if (alu_flags == FLAG_NEG) err[1] <= 1'b1;
          if (alu_flags == FLAG_INVALID) err[2] <= 1'b1;
          state       <= FETCH;
          instr_ready <= 1'b1;
        end
        WAITC: begin
          if (waitCnt == 4'd0) begin
            state       <= FETCH;
            instr_ready <= 1'b1;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        HALT: ;
        default: begin
          state       <= IDLE;
          instr_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with ALU stand-in and reference model
module tb_alu_sequencer;

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_MUL = 5'd2,  OP_DIV = 5'd3;
  localparam logic [4:0] OP_MOD = 5'd4,  OP_ANDB = 5'd5, OP_ORB = 5'd6,  OP_NOTB = 5'd7;
  localparam logic [4:0] OP_XORB = 5'd8, OP_TWOCOMP = 5'd9, OP_LSLN = 5'd10, OP_LSRN = 5'd11;
  localparam logic [4:0] OP_LSL = 5'd12, OP_LSR = 5'd13, OP_ASL = 5'd14, OP_ASR = 5'd15;
  localparam logic [4:0] OP_RSL = 5'd16, OP_RSR = 5'd17, OP_CPY = 5'd18;
  localparam logic [4:0] OP_CMPLT = 5'd19, OP_CMPGT = 5'd20, OP_CMPEQ = 5'd21, OP_CMPNE = 5'd22;
  localparam logic [4:0] OP_START = 5'd23, OP_END = 5'd24, OP_WAIT = 5'd25, OP_LDR = 5'd26;
  localparam logic [4:0] OP_STR = 5'd27, OP_DISPB = 5'd28, OP_DISPH = 5'd29, OP_UNUSED = 5'd30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] instrIn = '0;
  logic        instrValid = 1'b0;
  logic        instrReady;
  logic [13:0] ldData = '0;
  logic [13:0] stData;
  logic        stValid;
  logic [13:0] dispData;
  logic        dispValid;
  logic        dispHex;
  logic [4:0]  aluOp;
  logic [13:0] aluA;
  logic [13:0] aluB;
  logic        aluRstFlags;
  logic [13:0] aluRes;
  logic [2:0]  aluFlg;
  logic        running;
  logic        halted;
  logic        cond;
  logic        parity;
  logic [3:0]  err;

  int errors = 0;
  int checks = 0;

  logic [13:0] mReg [16];
  logic [3:0]  mErr;
  logic        mCond;
  logic        mParity;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .instr_in(instrIn), .instr_valid(instrValid), .instr_ready(instrReady),
    .ld_data(ldData), .st_data(stData), .st_valid(stValid), .disp_data(dispData),
    .disp_valid(dispValid), .disp_hex(dispHex), .alu_op(aluOp), .alu_a(aluA), .alu_b(aluB),
    .alu_rst_flags(aluRstFlags), .alu_result(aluRes), .alu_flags(aluFlg), .running(running),
    .halted(halted), .cond(cond), .parity(parity), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  // ALU behaviour: returns {flags, result}.
  function automatic logic [16:0] aluEval(input logic [4:0] op, input logic [13:0] a, input logic [13:0] b);
    logic [14:0] s;
    logic [27:0] p;
    logic [13:0] r;
    logic [2:0]  f;
    r = '0; f = 3'd0; s = '0; p = '0;
    case (op)
      OP_ADD: begin s = 15'(a) + 15'(b); if (s > 15'd16383) f = 3'd3; else r = s[13:0]; end
      OP_SUB: if (a < b) f = 3'd4; else r = a - b;
      OP_MUL: begin p = 28'(a) * 28'(b); if (p > 28'd16383) f = 3'd3; else r = p[13:0]; end
      OP_DIV: if (b == 14'd0) begin r = a; f = 3'd5; end else r = a / b;
      OP_MOD: f = a[0] ? 3'd7 : 3'd6;
      OP_ANDB: r = a & b;
      OP_ORB: r = a | b;
      OP_NOTB: r = ~a;
      OP_XORB: r = a ^ b;
      OP_TWOCOMP: r = ~a + 14'd1;
      OP_LSLN: r = a << b[3:0];
      OP_LSRN: r = a >> b[3:0];
      OP_LSL, OP_ASL: r = a << 1;
      OP_LSR: r = a >> 1;
      OP_ASR: r = {a[13], a[13:1]};
      OP_RSL: r = {a[12:0], a[13]};
      OP_RSR: r = {a[0], a[13:1]};
      OP_CPY: r = a;
      OP_CMPLT: f = (a < b) ? 3'd1 : 3'd2;
      OP_CMPGT: f = (a > b) ? 3'd1 : 3'd2;
      OP_CMPEQ: f = (a == b) ? 3'd1 : 3'd2;
      OP_CMPNE: f = (a != b) ? 3'd1 : 3'd2;
      default: ;
    endcase
    return {f, r};
  endfunction

  // ALU stand-in: registered result, asynchronous clear.
  always @(posedge clk or posedge aluRstFlags) begin
    if (aluRstFlags) {aluFlg, aluRes} <= '0;
    else {aluFlg, aluRes} <= aluEval(aluOp, aluA, aluB);
  end

  function automatic logic [16:0] mk(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb);
    return {op, rd, ra, rb};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mReg[i] = '0;
    mErr = '0; mCond = 1'b0; mParity = 1'b0;
  endtask

  // Architectural effect of one ALU-class instruction.
  task automatic modelAlu(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb);
    logic [16:0] v;
    v = aluEval(op, mReg[ra], mReg[rb]);
    if (op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_ANDB, OP_ORB, OP_NOTB, OP_XORB, OP_TWOCOMP,
                   OP_LSLN, OP_LSRN, OP_LSL, OP_LSR, OP_ASL, OP_ASR, OP_RSL, OP_RSR, OP_CPY})
      mReg[rd] = v[13:0];
    else if (op inside {OP_CMPLT, OP_CMPGT, OP_CMPEQ, OP_CMPNE}) mCond = (v[16:14] == 3'd1);
    else if (op == OP_MOD) mParity = (v[16:14] == 3'd7);
    else mErr[3] = 1'b1;
    if (v[16:14] == 3'd3) mErr[0] = 1'b1;
    if (v[16:14] == 3'd4) mErr[1] = 1'b1;
    if (v[16:14] == 3'd5) mErr[2] = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [16:0] w);
    int n;
    n = 0;
    instrIn = w;
    instrValid = 1'b1;
    while (!instrReady && n < 50) begin @(negedge clk); n++; end
    if (!instrReady) begin
      checks++; errors++;
      $display("FAIL send_timeout: instr_ready=%0b after %0d cycles, required 1", instrReady, n);
    end
    @(posedge clk);
    @(negedge clk);
    instrValid = 1'b0;
  endtask

  task automatic sendLdr(input logic [3:0] rd, input logic [13:0] val);
    ldData = val;
    send(mk(OP_LDR, rd, 4'd0, 4'd0));
    mReg[rd] = val;
  endtask

  task automatic sendAlu(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb,
                         output int lowCycles, output int rfCycles);
    send(mk(op, rd, ra, rb));
    modelAlu(op, rd, ra, rb);
    lowCycles = 0; rfCycles = 0;
    while (!instrReady && lowCycles < 20) begin
      if (aluRstFlags) rfCycles++;
      lowCycles++;
      @(negedge clk);
    end
  endtask

  task automatic readReg(input logic [3:0] ra, output logic [13:0] d, output logic v0, output logic v1);
    send(mk(OP_STR, 4'd0, ra, 4'd0));
    d = stData; v0 = stValid;
    @(negedge clk);
    v1 = stValid;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (aluRstFlags !== 1'b1) begin errors++; $display("FAIL reset_alu_rst_flags: got %0b, required 1", aluRstFlags); end
    checks++; if (instrReady !== 1'b0) begin errors++; $display("FAIL reset_instr_ready: got %0b, required 0", instrReady); end
    checks++; if ({running, halted, cond, parity, err, stValid, dispValid} !== 10'd0) begin errors++;
      $display("FAIL reset_status: got %b, required 0", {running, halted, cond, parity, err, stValid, dispValid}); end
    checks++; if ({aluOp, aluA, aluB, stData, dispData} !== 61'd0) begin errors++;
      $display("FAIL reset_data_outputs: got %h, required 0", {aluOp, aluA, aluB, stData, dispData}); end
    rst = 1'b0;
    modelReset();
    @(negedge clk);
  endtask

  task automatic test_before_start();
    logic [13:0] d; logic v0, v1; int lo, rf;
    ldData = 14'd99;
    send(mk(OP_LDR, 4'd1, 4'd0, 4'd0));
    send(mk(OP_ADD, 4'd2, 4'd0, 4'd0));
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL idle_running: got %0b, required 0", running); end
    send(mk(OP_START, 4'd0, 4'd0, 4'd0));
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running: got %0b, required 1", running); end
    readReg(4'd1, d, v0, v1);
    checks++; if (d !== 14'd0) begin errors++; $display("FAIL discarded_ldr: r1 got %0d, required 0", d); end
    lo = 0; rf = 0;
  endtask

  task automatic test_basic();
    logic [13:0] d; logic v0, v1; int lo, rf;
    sendLdr(4'd1, 14'd5);
    sendLdr(4'd2, 14'd7);
    sendAlu(OP_ADD, 4'd3, 4'd1, 4'd2, lo, rf);
    checks++; if (lo != 3) begin errors++; $display("FAIL alu_busy_cycles: got %0d, required 3", lo); end
    checks++; if (rf != 1) begin errors++; $display("FAIL alu_rst_flags_cycles: got %0d, required 1", rf); end
    readReg(4'd3, d, v0, v1);
    checks++; if (d !== 14'd12) begin errors++; $display("FAIL add_store: st_data got %0d, required 12", d); end
    checks++; if ({v0, v1} !== 2'b10) begin errors++; $display("FAIL st_valid_pulse: got %b, required 10", {v0, v1}); end
  endtask

  task automatic test_alu_flags();
    logic [13:0] d; logic v0, v1; int lo, rf;
    sendLdr(4'd4, 14'd16383); sendLdr(4'd5, 14'd1);
    sendAlu(OP_ADD, 4'd6, 4'd4, 4'd5, lo, rf);
    readReg(4'd6, d, v0, v1);
    checks++; if (d !== 14'd0) begin errors++; $display("FAIL add_ovf_result: got %0d, required 0", d); end
    checks++; if (err !== 4'b0001) begin errors++; $display("FAIL add_ovf_err: got %b, required 0001", err); end
    sendLdr(4'd7, 14'd3); sendLdr(4'd8, 14'd5);
    sendAlu(OP_SUB, 4'd9, 4'd7, 4'd8, lo, rf);
    readReg(4'd9, d, v0, v1);
    checks++; if (d !== 14'd0) begin errors++; $display("FAIL sub_neg_result: got %0d, required 0", d); end
    checks++; if (err !== 4'b0011) begin errors++; $display("FAIL sub_neg_err: got %b, required 0011", err); end
    sendLdr(4'd10, 14'd9); sendLdr(4'd11, 14'd0);
    sendAlu(OP_DIV, 4'd12, 4'd10, 4'd11, lo, rf);
    readReg(4'd12, d, v0, v1);
    checks++; if (d !== 14'd9) begin errors++; $display("FAIL div0_result: got %0d, required 9", d); end
    checks++; if (err !== 4'b0111) begin errors++; $display("FAIL div0_err: got %b, required 0111", err); end
  endtask

  task automatic test_compare();
    logic [13:0] d; logic v0, v1; int lo, rf;
    sendLdr(4'd13, 14'd1234);
    sendAlu(OP_CMPLT, 4'd13, 4'd7, 4'd8, lo, rf);
    checks++; if (cond !== 1'b1) begin errors++; $display("FAIL cmplt_cond: got %0b, required 1", cond); end
    sendAlu(OP_CMPEQ, 4'd13, 4'd7, 4'd8, lo, rf);
    checks++; if (cond !== 1'b0) begin errors++; $display("FAIL cmpeq_cond: got %0b, required 0", cond); end
    sendLdr(4'd14, 14'd7);
    sendAlu(OP_MOD, 4'd13, 4'd14, 4'd0, lo, rf);
    checks++; if (parity !== 1'b1) begin errors++; $display("FAIL mod7_parity: got %0b, required 1", parity); end
    sendLdr(4'd14, 14'd4);
    sendAlu(OP_MOD, 4'd13, 4'd14, 4'd0, lo, rf);
    checks++; if (parity !== 1'b0) begin errors++; $display("FAIL mod4_parity: got %0b, required 0", parity); end
    readReg(4'd13, d, v0, v1);
    checks++; if (d !== 14'd1234) begin errors++; $display("FAIL compare_rd_untouched: got %0d, required 1234", d); end
  endtask

  task automatic test_unused();
    logic [13:0] d; logic v0, v1; int lo, rf;
    sendAlu(OP_UNUSED, 4'd13, 4'd7, 4'd8, lo, rf);
    checks++; if (err[3] !== 1'b1) begin errors++; $display("FAIL unused_err3: got %0b, required 1", err[3]); end
    readReg(4'd13, d, v0, v1);
    checks++; if (d !== 14'd1234) begin errors++; $display("FAIL unused_no_wb: got %0d, required 1234", d); end
  endtask

  task automatic test_random();
    logic [13:0] d; logic v0, v1; int lo, rf;
    logic [4:0] op; logic [3:0] rd, ra, rb;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 0) sendLdr(4'(i), 14'($urandom_range(0, 16383)));
      else sendLdr(4'(i), 14'($urandom_range(0, 40)));
    end
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 13))
        0: op = OP_ADD;   1: op = OP_SUB;   2: op = OP_MUL;   3: op = OP_DIV;
        4: op = OP_XORB;  5: op = OP_ANDB;  6: op = OP_RSL;   7: op = OP_LSRN;
        8: op = OP_CMPLT; 9: op = OP_CMPNE; 10: op = OP_MOD;  11: op = OP_CPY;
        12: op = OP_TWOCOMP; default: op = OP_ASR;
      endcase
      rd = 4'($urandom_range(0, 15)); ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
      sendAlu(op, rd, ra, rb, lo, rf);
      readReg(rd, d, v0, v1);
      checks++; if (d !== mReg[rd]) begin errors++;
        $display("FAIL rand_reg: op=%0d r%0d got %0d, required %0d", op, rd, d, mReg[rd]); end
      checks++; if ({cond, parity} !== {mCond, mParity}) begin errors++;
        $display("FAIL rand_cond_parity: op=%0d got %b, required %b", op, {cond, parity}, {mCond, mParity}); end
    end
    checks++; if (err !== mErr) begin errors++; $display("FAIL rand_err: got %b, required %b", err, mErr); end
  endtask

  task automatic test_wait();
    int lo;
    send(mk(OP_WAIT, 4'd0, 4'd0, 4'd3));
    lo = 0;
    while (!instrReady && lo < 20) begin lo++; @(negedge clk); end
    checks++; if (lo != 4) begin errors++; $display("FAIL wait3_cycles: got %0d, required 4", lo); end
    send(mk(OP_WAIT, 4'd0, 4'd0, 4'd0));
    lo = 0;
    while (!instrReady && lo < 20) begin lo++; @(negedge clk); end
    checks++; if (lo != 1) begin errors++; $display("FAIL wait0_cycles: got %0d, required 1", lo); end
  endtask

  task automatic test_disp();
    logic v1;
    send(mk(OP_DISPH, 4'd0, 4'd3, 4'd0));
    checks++; if ({dispValid, dispHex, dispData} !== {2'b11, mReg[3]}) begin errors++;
      $display("FAIL disph: got %b/%b/%0d, required 1/1/%0d", dispValid, dispHex, dispData, mReg[3]); end
    @(negedge clk); v1 = dispValid;
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL disp_pulse: got %0b, required 0", v1); end
    send(mk(OP_DISPB, 4'd0, 4'd5, 4'd0));
    checks++; if ({dispValid, dispHex, dispData} !== {2'b10, mReg[5]}) begin errors++;
      $display("FAIL dispb: got %b/%b/%0d, required 1/0/%0d", dispValid, dispHex, dispData, mReg[5]); end
  endtask

  task automatic test_reset_midexec();
    logic [13:0] d; logic v0, v1;
    sendLdr(4'd1, 14'd100); sendLdr(4'd2, 14'd200); sendLdr(4'd3, 14'd1);
    send(mk(OP_ADD, 4'd3, 4'd1, 4'd2));
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({running, halted, cond, parity, err, stValid, dispValid, instrReady} !== 11'd0) begin errors++;
      $display("FAIL midexec_status: got %b, required 0", {running, halted, cond, parity, err, stValid, dispValid, instrReady}); end
    checks++; if ({aluRstFlags, aluOp, aluA, aluB} !== {1'b1, 33'd0}) begin errors++;
      $display("FAIL midexec_alu_outputs: got %h, required %h", {aluRstFlags, aluOp, aluA, aluB}, {1'b1, 33'd0}); end
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    send(mk(OP_START, 4'd0, 4'd0, 4'd0));
    readReg(4'd3, d, v0, v1);
    checks++; if (d !== 14'd0) begin errors++; $display("FAIL midexec_no_wb: r3 got %0d, required 0", d); end
    repeat (4) @(negedge clk);
    checks++; if (err !== 4'd0) begin errors++; $display("FAIL midexec_err: got %b, required 0000", err); end
  endtask

  task automatic test_end();
    int hi;
    send(mk(OP_END, 4'd0, 4'd0, 4'd0));
    checks++; if ({halted, running} !== 2'b10) begin errors++; $display("FAIL end_status: got %b, required 10", {halted, running}); end
    instrIn = mk(OP_START, 4'd0, 4'd0, 4'd0);
    instrValid = 1'b1;
    hi = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (instrReady) hi++; end
    instrValid = 1'b0;
    checks++; if (hi != 0) begin errors++; $display("FAIL halt_ready: high %0d cycles, required 0", hi); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_hold: got %0b, required 1", halted); end
  endtask

  initial begin
    test_reset();
    test_before_start();
    test_basic();
    test_alu_flags();
    test_compare();
    test_unused();
    test_random();
    test_wait();
    test_disp();
    test_reset_midexec();
    test_end();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
